// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: FSM encoding, alignment mask and default
// bus timeout.
package mem_pkg;

    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_BUSY = 1'b1
    } state_e;

    localparam logic [1:0] ALIGN_MASK      = 2'b11;
    localparam int         DEFAULT_TIMEOUT = 16;

    // A word access is misaligned when either low address bit is set.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. It can insert a bubble, latch with the register write
// suppressed, and capture load data on request.
module mem_wb_reg #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en_i,
    input  logic          bubble_i,
    input  logic          kill_regwrite_i,
    input  logic          rd_sel_i,
    input  logic          memtoreg_i,
    input  logic          regwrite_i,
    input  logic [DW-1:0] alu_i,
    input  logic [4:0]    wn_i,
    input  logic [DW-1:0] rdata_i,
    output logic          memtoreg_o,
    output logic          regwrite_o,
    output logic [DW-1:0] alu_o,
    output logic [4:0]    wn_o,
    output logic [DW-1:0] rd_o
);

    logic          memtoreg_q;
    logic          regwrite_q;
    logic [DW-1:0] alu_q;
    logic [4:0]    wn_q;
    logic [DW-1:0] rd_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
            alu_q      <= '0;
            wn_q       <= '0;
            rd_q       <= '0;
        end else if (bubble_i) begin
            // A bubble only clears the control bits; the data fields keep their values.
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
        end else if (load_en_i) begin
            memtoreg_q <= memtoreg_i;
            regwrite_q <= regwrite_i & ~kill_regwrite_i;
            alu_q      <= alu_i;
            wn_q       <= wn_i;
            if (rd_sel_i) begin
                rd_q <= rdata_i;
            end
        end
    end

    assign memtoreg_o = memtoreg_q;
    assign regwrite_o = regwrite_q;
    assign alu_o      = alu_q;
    assign wn_o       = wn_q;
    assign rd_o       = rd_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage controller. It runs the data-memory req/ack handshake, stalls the
// upstream stages, flags misalignment and timeouts, and feeds the MEM/WB register.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          MemtoReg_out_from_EX,
    input  logic          RegWrite_out_from_EX,
    input  logic          MemRead_out_from_EX,
    input  logic          MemWrite_out_from_EX,
    input  logic [DW-1:0] alu_out_out,
    input  logic [DW-1:0] mem_wd,
    input  logic [4:0]    rfile_wn_out,
    output logic          stall_mem,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ack,
    output logic          MemtoReg_out_from_MEM,
    output logic          RegWrite_out_from_MEM,
    output logic [DW-1:0] mem_rd_out,
    output logic [DW-1:0] alu_out_wb,
    output logic [4:0]    rfile_wn_wb,
    output logic          err_misalign,
    output logic          err_timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          err_mis_q, err_mis_d;
    logic          err_to_q, err_to_d;

    logic          acc;
    logic          mis;
    logic          at_limit;
    logic          wb_load;
    logic          wb_bubble;
    logic          wb_kill;
    logic          wb_rd_sel;

    assign acc      = MemRead_out_from_EX | MemWrite_out_from_EX;
    assign mis      = acc & is_misaligned(alu_out_out[1:0]);
    assign at_limit = (cnt_q >= CW'(TIMEOUT));

    // NOTE: every output of this block gets a default before the case statement,
    // so no path can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_mis_d = 1'b0;
        err_to_d  = 1'b0;
        stall_mem = 1'b0;
        wb_load   = 1'b0;
        wb_bubble = 1'b0;
        wb_kill   = 1'b0;
        wb_rd_sel = 1'b0;

        case (state_q)
            STATE_IDLE: begin
                if (mis) begin
                    wb_load   = 1'b1;
                    wb_kill   = 1'b1;
                    err_mis_d = 1'b1;
                end else if (acc) begin
                    stall_mem = 1'b1;
                    state_d   = STATE_BUSY;
                    cnt_d     = CW'(1);
                    req_d     = 1'b1;
                    we_d      = MemWrite_out_from_EX;
                    addr_d    = AW'(alu_out_out);
                    wdata_d   = mem_wd;
                    wb_bubble = 1'b1;
                end else begin
                    wb_load = 1'b1;
                end
            end
            STATE_BUSY: begin
                // An ack in the timeout cycle still completes the access normally.
                if (dmem_ack) begin
                    state_d   = STATE_IDLE;
                    cnt_d     = '0;
                    req_d     = 1'b0;
                    wb_load   = 1'b1;
                    wb_rd_sel = MemRead_out_from_EX;
                end else if (at_limit) begin
                    state_d  = STATE_IDLE;
                    cnt_d    = '0;
                    req_d    = 1'b0;
                    wb_load  = 1'b1;
                    wb_kill  = 1'b1;
                    err_to_d = 1'b1;
                end else begin
                    stall_mem = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= STATE_IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_mis_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_mis_q <= err_mis_d;
            err_to_q  <= err_to_d;
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign err_misalign = err_mis_q;
    assign err_timeout  = err_to_q;

    mem_wb_reg #(
        .DW (DW)
    ) u_mem_wb_reg (
        .clk             (clk),
        .rst             (rst),
        .load_en_i       (wb_load),
        .bubble_i        (wb_bubble),
        .kill_regwrite_i (wb_kill),
        .rd_sel_i        (wb_rd_sel),
        .memtoreg_i      (MemtoReg_out_from_EX),
        .regwrite_i      (RegWrite_out_from_EX),
        .alu_i           (alu_out_out),
        .wn_i            (rfile_wn_out),
        .rdata_i         (dmem_rdata),
        .memtoreg_o      (MemtoReg_out_from_MEM),
        .regwrite_o      (RegWrite_out_from_MEM),
        .alu_o           (alu_out_wb),
        .wn_o            (rfile_wn_wb),
        .rd_o            (mem_rd_out)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage. Expected MEM/WB contents are queued when an
// instruction is driven and compared once the stage retires it.
module tb_mem_access_stage;

    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic        mt;
        logic        rw;
        logic [31:0] alu;
        logic [4:0]  wn;
        logic [31:0] rd;
    } wb_t;

    logic        clk;
    logic        rst;
    logic        memtoreg_ex, regwrite_ex, memread_ex, memwrite_ex;
    logic [31:0] alu_ex, wd_ex;
    logic [4:0]  wn_ex;
    logic        stall_mem, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        memtoreg_wb, regwrite_wb;
    logic [31:0] mem_rd_out, alu_out_wb;
    logic [4:0]  rfile_wn_wb;
    logic        err_misalign, err_timeout;

    int          vectors;
    int          miscompares;
    wb_t         exp_q[$];
    logic [31:0] exp_rd;

    mem_access_stage #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .MemtoReg_out_from_EX  (memtoreg_ex),
        .RegWrite_out_from_EX  (regwrite_ex),
        .MemRead_out_from_EX   (memread_ex),
        .MemWrite_out_from_EX  (memwrite_ex),
        .alu_out_out           (alu_ex),
        .mem_wd                (wd_ex),
        .rfile_wn_out          (wn_ex),
        .stall_mem             (stall_mem),
        .dmem_req              (dmem_req),
        .dmem_we               (dmem_we),
        .dmem_addr             (dmem_addr),
        .dmem_wdata            (dmem_wdata),
        .dmem_rdata            (dmem_rdata),
        .dmem_ack              (dmem_ack),
        .MemtoReg_out_from_MEM (memtoreg_wb),
        .RegWrite_out_from_MEM (regwrite_wb),
        .mem_rd_out            (mem_rd_out),
        .alu_out_wb            (alu_out_wb),
        .rfile_wn_wb           (rfile_wn_wb),
        .err_misalign          (err_misalign),
        .err_timeout           (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic mt, input logic rw, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] d, input logic [4:0] n);
        memtoreg_ex = mt;
        regwrite_ex = rw;
        memread_ex  = rd;
        memwrite_ex = wr;
        alu_ex      = a;
        wd_ex       = d;
        wn_ex       = n;
    endtask

    task automatic drive_nop();
        drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic push_wb(input logic mt, input logic rw, input logic [31:0] a, input logic [4:0] n);
        wb_t e;
        e.mt  = mt;
        e.rw  = rw;
        e.alu = a;
        e.wn  = n;
        e.rd  = exp_rd;
        exp_q.push_back(e);
    endtask

    task automatic compare_wb(input string tag);
        wb_t e;
        check({tag, "_queue"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_memtoreg"}, 64'(memtoreg_wb), 64'(e.mt));
            check({tag, "_regwrite"}, 64'(regwrite_wb), 64'(e.rw));
            check({tag, "_alu_wb"},   64'(alu_out_wb),  64'(e.alu));
            check({tag, "_wn_wb"},    64'(rfile_wn_wb), 64'(e.wn));
            check({tag, "_mem_rd"},   64'(mem_rd_out),  64'(e.rd));
        end
    endtask

    task automatic check_regs_zero(input string tag);
        check({tag, "_req"},      64'(dmem_req),     64'd0);
        check({tag, "_we"},       64'(dmem_we),      64'd0);
        check({tag, "_addr"},     64'(dmem_addr),    64'd0);
        check({tag, "_wdata"},    64'(dmem_wdata),   64'd0);
        check({tag, "_memtoreg"}, 64'(memtoreg_wb),  64'd0);
        check({tag, "_regwrite"}, 64'(regwrite_wb),  64'd0);
        check({tag, "_mem_rd"},   64'(mem_rd_out),   64'd0);
        check({tag, "_alu_wb"},   64'(alu_out_wb),   64'd0);
        check({tag, "_wn_wb"},    64'(rfile_wn_wb),  64'd0);
        check({tag, "_err_mis"},  64'(err_misalign), 64'd0);
        check({tag, "_err_to"},   64'(err_timeout),  64'd0);
    endtask

    task automatic alu_op(input string tag, input logic rw, input logic mt,
                          input logic [31:0] a, input logic [4:0] n);
        drive_ex(mt, rw, 1'b0, 1'b0, a, 32'h0, n);
        #1;
        check({tag, "_stall"}, 64'(stall_mem), 64'd0);
        push_wb(mt, rw, a, n);
        tick();
        drive_nop();
        check({tag, "_req"}, 64'(dmem_req), 64'd0);
        compare_wb(tag);
    endtask

    // ack_on = BUSY cycle in which dmem_ack is driven; 0 means never (timeout).
    task automatic mem_access(input string tag, input logic is_store, input logic [31:0] a,
                              input logic [31:0] wdata, input int ack_on,
                              input logic [31:0] rdata, input logic [4:0] n);
        int  stalls;
        bit  done;
        logic rw_exp;
        drive_ex(~is_store, ~is_store, ~is_store, is_store, a, wdata, n);
        dmem_rdata = 32'h5555_0000 ^ a;
        #1;
        stalls = 0;
        if (stall_mem) stalls++;
        check({tag, "_req_idle"}, 64'(dmem_req), 64'd0);
        rw_exp = ~is_store & (ack_on != 0);
        if (~is_store && ack_on != 0) exp_rd = rdata;
        push_wb(~is_store, rw_exp, a, n);
        done = 1'b0;
        for (int c = 1; c <= TIMEOUT + 4 && !done; c++) begin
            tick();
            check({tag, "_req_busy"},   64'(dmem_req),    64'd1);
            check({tag, "_we_busy"},    64'(dmem_we),     64'(is_store));
            check({tag, "_addr_busy"},  64'(dmem_addr),   64'(a));
            check({tag, "_wdata_busy"}, 64'(dmem_wdata),  64'(wdata));
            check({tag, "_rw_bubble"},  64'(regwrite_wb), 64'd0);
            if (c == ack_on) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            #1;
            if (stall_mem) stalls++;
            else done = 1'b1;
        end
        check({tag, "_completed"}, 64'(done), 64'd1);
        check({tag, "_stall_cycles"}, 64'(stalls), (ack_on == 0) ? 64'(TIMEOUT) : 64'(ack_on));
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0BAD_F00D;
        drive_nop();
        check({tag, "_req_done"}, 64'(dmem_req),     64'd0);
        check({tag, "_err_to"},   64'(err_timeout),  64'(ack_on == 0));
        check({tag, "_err_mis"},  64'(err_misalign), 64'd0);
        compare_wb(tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_rd      = 32'h0;
        rst         = 1'b1;
        dmem_ack    = 1'b0;
        dmem_rdata  = 32'h0;
        drive_nop();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_regs_zero("reset");
        check("reset_stall", 64'(stall_mem), 64'd0);
        #3 rst = 1'b0;
        tick();

        // Plain ALU op, single-cycle pass-through
        alu_op("alu", 1'b1, 1'b0, 32'h0000_1234, 5'd5);
        alu_op("alu2", 1'b1, 1'b0, 32'hFFFF_FFF0, 5'd31);

        // Load acked on first BUSY cycle
        mem_access("load", 1'b0, 32'h0000_0100, 32'h0, 1, 32'hDEAD_BEEF, 5'd7);

        // Store acked on third BUSY cycle
        mem_access("store", 1'b1, 32'h0000_0204, 32'hA5A5_A5A5, 3, 32'h0, 5'd0);

        // Misaligned load: no request, write suppressed, one-cycle error
        drive_ex(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd9);
        #1;
        check("mis_stall", 64'(stall_mem), 64'd0);
        push_wb(1'b1, 1'b0, 32'h0000_0102, 5'd9);
        tick();
        drive_nop();
        check("mis_req", 64'(dmem_req), 64'd0);
        check("mis_err", 64'(err_misalign), 64'd1);
        compare_wb("mis");
        tick();
        check("mis_err_clear", 64'(err_misalign), 64'd0);
        check("mis_req_after", 64'(dmem_req), 64'd0);

        // Load that never gets acked times out
        mem_access("timeout", 1'b0, 32'h0000_0400, 32'h0, 0, 32'h0, 5'd11);
        tick();
        check("timeout_err_clear", 64'(err_timeout), 64'd0);

        // Late ack in IDLE is ignored and load data holds
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1357_9BDF;
        alu_op("late_ack", 1'b1, 1'b0, 32'h0000_0042, 5'd3);
        dmem_ack = 1'b0;

        // Ack arriving in the timeout cycle wins
        mem_access("ack_at_limit", 1'b0, 32'h0000_0800, 32'h0, TIMEOUT, 32'hCAFE_F00D, 5'd12);

        // Asynchronous reset in the middle of an access
        drive_ex(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd3);
        tick();
        check("rst_mid_req_before", 64'(dmem_req), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_regs_zero("rst_mid");
        exp_rd = 32'h0;
        drive_nop();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h7777_7777;
        tick();
        #3 rst = 1'b0;
        tick();
        check("post_rst_req", 64'(dmem_req), 64'd0);
        check("post_rst_mem_rd", 64'(mem_rd_out), 64'd0);
        dmem_ack = 1'b0;
        tick();

        // Normal load after reset
        mem_access("load_after_rst", 1'b0, 32'h0000_0104, 32'h0, 2, 32'h0123_4567, 5'd14);
        alu_op("final_alu", 1'b0, 1'b0, 32'h0000_0008, 5'd1);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
